// File: rtl/cram_diag_seq_pkg.sv
// Shared EBOX definitions for the CRAM diagnostic write/read sequencer:
// CRAM address type, DIAG function codes and sequencer states.
package cram_diag_seq_pkg;

    typedef logic [10:0] tCRADR;
    typedef logic [1:0]  slice_idx_t;

    localparam logic [2:0] CDS_CLEAR    = 3'd0;
    localparam logic [2:0] CDS_ADR_LO   = 3'd1;
    localparam logic [2:0] CDS_ADR_HI   = 3'd2;
    localparam logic [2:0] CDS_COMMIT   = 3'd3;
    localparam logic [2:0] CDS_WR_60_79 = 3'd4;
    localparam logic [2:0] CDS_WR_40_59 = 3'd5;
    localparam logic [2:0] CDS_WR_20_39 = 3'd6;
    localparam logic [2:0] CDS_WR_00_19 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_READ,
        ST_RDATA
    } cds_state_t;

    // Slice index counts from the MSB end: 0 = bits 00_19, 3 = bits 60_79.
    function automatic slice_idx_t slice_of_code(input logic [2:0] code);
        return slice_idx_t'(3'd7 - code);
    endfunction

endpackage

// File: rtl/cram_slice_asm.sv
// Microword slice assembly: four 20-bit slice registers with a load mask,
// plus the latched read-back slice select and mux.
module cram_slice_asm
    import cram_diag_seq_pkg::*;
(
    input  logic        clk,
    input  logic        RESET,
    input  logic        clr,
    input  logic        ld,
    input  slice_idx_t  ld_idx,
    input  logic [19:0] ld_data,
    input  logic        mask_clr,
    input  logic        rd_sel_ld,
    input  slice_idx_t  rd_sel,
    input  logic [79:0] rdata,
    output logic [3:0]  mask,
    output logic [79:0] wdata,
    output logic [19:0] rd_slice_data
);

    logic [19:0] rd_slices [4];
    slice_idx_t  rd_sel_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            logic [19:0] data_reg;
            logic        valid_reg;

            // Reloading a slice overwrites data; the mask bit simply stays set.
            always_ff @(posedge clk) begin
                if (RESET || clr) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (ld && (ld_idx == slice_idx_t'(gi))) begin
                    data_reg  <= ld_data;
                    valid_reg <= 1'b1;
                end else if (mask_clr) begin
                    valid_reg <= 1'b0;
                end
            end

            assign mask[gi]               = valid_reg;
            assign wdata[79-20*gi -: 20]  = data_reg;
            assign rd_slices[gi]          = rdata[79-20*gi -: 20];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (RESET) begin
            rd_sel_reg <= '0;
        end else if (rd_sel_ld) begin
            rd_sel_reg <= rd_sel;
        end
    end

    assign rd_slice_data = rd_slices[rd_sel_reg];

endmodule

// File: rtl/cram_diag_seq.sv
// CRAM diagnostic sequencer: collects address/slices from DIAG functions,
// commits one-cycle CRAM writes and performs slice read-back.
// Optional odd parity on bit 79 and read check: define CRAM_DIAG_PARITY_EN.
module cram_diag_seq
    import cram_diag_seq_pkg::*;
(
    input  logic        clk,
    input  logic        RESET,
    input  logic        func_valid,
    input  logic [2:0]  func_code,
    input  logic [35:0] ebus_data,
    input  logic        rd_req,
    input  logic [1:0]  rd_slice,
    output logic        ready,
    output tCRADR       cram_adr,
    output logic [79:0] cram_wdata,
    output logic        cram_we,
    output logic        cram_re,
    input  logic [79:0] cram_rdata,
    output logic        rd_valid,
    output logic [19:0] rd_data,
    output logic        err,
    output logic        busy
);

    cds_state_t  state_reg, state_next;
    tCRADR       adr_reg;
    logic        err_reg;

    logic        idle_like;
    logic        func_acc;
    logic        rd_acc;
    logic        do_clear;
    logic        slice_ld;
    logic        adr_ld;
    logic        commit_ok;
    logic        commit_bad;
    logic [3:0]  mask;
    logic [79:0] slice_wdata;
    logic [19:0] rd_slice_data;
    logic        wr_par;
    logic        rd_par_bad;
    logic        unused_ebus;

    assign idle_like  = (state_reg == ST_IDLE) || (state_reg == ST_COLLECT);
    assign func_acc   = func_valid && idle_like;
    // A function strobe always wins over a simultaneous read request.
    assign rd_acc     = rd_req && idle_like && !func_valid;
    assign do_clear   = func_acc && (func_code == CDS_CLEAR);
    assign slice_ld   = func_acc && func_code[2];
    assign adr_ld     = func_acc && ((func_code == CDS_ADR_LO) || (func_code == CDS_ADR_HI));
    assign commit_ok  = func_acc && (func_code == CDS_COMMIT) && (mask == 4'b1111);
    assign commit_bad = func_acc && (func_code == CDS_COMMIT) && (mask != 4'b1111);
    assign unused_ebus = ^ebus_data[15:0];

`ifdef CRAM_DIAG_PARITY_EN
    assign wr_par     = ~^slice_wdata[79:1];
    assign rd_par_bad = (state_reg == ST_RDATA) && !(^cram_rdata);
`else
    assign wr_par     = slice_wdata[0];
    assign rd_par_bad = 1'b0;
`endif

    cram_slice_asm u_slice_asm (
        .clk           (clk),
        .RESET         (RESET),
        .clr           (do_clear),
        .ld            (slice_ld),
        .ld_idx        (slice_of_code(func_code)),
        .ld_data       (ebus_data[35:16]),
        .mask_clr      (commit_ok),
        .rd_sel_ld     (rd_acc),
        .rd_sel        (rd_slice),
        .rdata         (cram_rdata),
        .mask          (mask),
        .wdata         (slice_wdata),
        .rd_slice_data (rd_slice_data)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_COLLECT: begin
                if (slice_ld || adr_ld) begin
                    state_next = ST_COLLECT;
                end else if (commit_ok) begin
                    state_next = ST_WRITE;
                end else if (rd_acc) begin
                    state_next = ST_READ;
                end
            end
            ST_WRITE: state_next = ST_IDLE;
            ST_READ:  state_next = ST_RDATA;
            ST_RDATA: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Strobes are gated by RESET so an aborted cycle never reaches the CRAM.
    always_comb begin
        ready      = idle_like;
        busy       = !idle_like;
        cram_we    = (state_reg == ST_WRITE) && !RESET;
        cram_re    = (state_reg == ST_READ) && !RESET;
        rd_valid   = (state_reg == ST_RDATA) && !RESET;
        rd_data    = '0;
        if (rd_valid) begin
            rd_data = rd_slice_data;
        end
        cram_wdata = {slice_wdata[79:1], (state_reg == ST_WRITE) ? wr_par : slice_wdata[0]};
    end

    // ebus bit 0 is the MSB, so ebus[0:5] is ebus_data[35:30].
    always_ff @(posedge clk) begin
        if (RESET) begin
            adr_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (do_clear) begin
                err_reg <= 1'b0;
            end else if (commit_bad || rd_par_bad) begin
                err_reg <= 1'b1;
            end
            if (func_acc && (func_code == CDS_ADR_LO)) begin
                adr_reg[5:0] <= ebus_data[35:30];
            end
            if (func_acc && (func_code == CDS_ADR_HI)) begin
                adr_reg[10:6] <= ebus_data[34:30];
            end
        end
    end

    assign cram_adr = adr_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_cram_diag_seq.sv
// Directed and randomized bench for cram_diag_seq against a transaction-level
// model of the address, slices, mask, sticky error and a CRAM image.
module tb_cram_diag_seq;

    logic        clk = 1'b0;
    logic        RESET;
    logic        func_valid;
    logic [2:0]  func_code;
    logic [35:0] ebus_data;
    logic        rd_req;
    logic [1:0]  rd_slice;
    logic        ready;
    logic [10:0] cram_adr;
    logic [79:0] cram_wdata;
    logic        cram_we;
    logic        cram_re;
    logic [79:0] cram_rdata;
    logic        rd_valid;
    logic [19:0] rd_data;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    cram_diag_seq dut (
        .clk        (clk),
        .RESET      (RESET),
        .func_valid (func_valid),
        .func_code  (func_code),
        .ebus_data  (ebus_data),
        .rd_req     (rd_req),
        .rd_slice   (rd_slice),
        .ready      (ready),
        .cram_adr   (cram_adr),
        .cram_wdata (cram_wdata),
        .cram_we    (cram_we),
        .cram_re    (cram_re),
        .cram_rdata (cram_rdata),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .err        (err),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: slice 0 holds bits 00_19 (the MSB end of the word).
    logic [10:0] m_adr;
    logic [19:0] m_slice [4];
    logic [3:0]  m_mask;
    logic        m_err;
    logic [79:0] mem [logic [10:0]];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_adr  = '0;
        m_mask = '0;
        m_err  = 1'b0;
        for (int i = 0; i < 4; i++) m_slice[i] = '0;
    endtask

    function automatic logic [79:0] exp_wdata();
        logic [79:0] w;
        w = {m_slice[0], m_slice[1], m_slice[2], m_slice[3]};
`ifdef CRAM_DIAG_PARITY_EN
        w[0] = ~^w[79:1];
`endif
        return w;
    endfunction

    function automatic logic [79:0] rand80();
        return 80'({$urandom, $urandom, $urandom});
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 80'(ready), 80'(1'b1));
        chk({tag, "_busy"}, 80'(busy), 80'(1'b0));
        chk({tag, "_we"}, 80'(cram_we), 80'(1'b0));
        chk({tag, "_re"}, 80'(cram_re), 80'(1'b0));
        chk({tag, "_rdv"}, 80'(rd_valid), 80'(1'b0));
        chk({tag, "_err"}, 80'(err), 80'(1'b0));
        chk({tag, "_adr"}, 80'(cram_adr), 80'(11'd0));
        chk({tag, "_wdata"}, cram_wdata, 80'd0);
        chk({tag, "_rdata"}, 80'(rd_data), 80'(20'd0));
    endtask

    task automatic do_func(input logic [2:0] code, input logic [35:0] data);
        func_valid = 1'b1;
        func_code  = code;
        ebus_data  = data;
        tick();
        func_valid = 1'b0;
        $display("func code=%0d data=%h", code, data);
        case (code)
            3'd0: begin
                m_mask = '0;
                m_err  = 1'b0;
                for (int i = 0; i < 4; i++) m_slice[i] = '0;
            end
            3'd1: m_adr = {m_adr[10:6], 6'(data >> 30)};
            3'd2: m_adr = {5'(data >> 30), m_adr[5:0]};
            3'd3: begin
                if (m_mask == 4'b1111) begin
                    chk("commit_we", 80'(cram_we), 80'(1'b1));
                    chk("commit_busy", 80'(busy), 80'(1'b1));
                    chk("commit_ready", 80'(ready), 80'(1'b0));
                    chk("commit_adr", 80'(cram_adr), 80'(m_adr));
                    chk("commit_wdata", cram_wdata, exp_wdata());
                    mem[m_adr] = exp_wdata();
                    m_mask = '0;
                    tick();
                    chk("commit_we_once", 80'(cram_we), 80'(1'b0));
                end else begin
                    m_err = 1'b1;
                    chk("bad_commit_we", 80'(cram_we), 80'(1'b0));
                end
            end
            default: begin
                m_slice[7 - int'(code)] = 20'(data >> 16);
                m_mask[7 - int'(code)]  = 1'b1;
            end
        endcase
        chk("func_err", 80'(err), 80'(m_err));
        chk("func_ready", 80'(ready), 80'(1'b1));
        chk("func_adr", 80'(cram_adr), 80'(m_adr));
    endtask

    task automatic do_read(input logic [1:0] sel, input logic [79:0] rdata);
        rd_req   = 1'b1;
        rd_slice = sel;
        tick();
        rd_req   = 1'b0;
        rd_slice = 2'($urandom);
        $display("read adr=%o slice=%0d rdata=%h", m_adr, sel, rdata);
        chk("rd_re", 80'(cram_re), 80'(1'b1));
        chk("rd_ready", 80'(ready), 80'(1'b0));
        chk("rd_early_valid", 80'(rd_valid), 80'(1'b0));
        cram_rdata = rdata;
        tick();
        chk("rd_re_once", 80'(cram_re), 80'(1'b0));
        chk("rd_valid", 80'(rd_valid), 80'(1'b1));
        chk("rd_data", 80'(rd_data), 80'(20'(rdata >> (20 * (3 - int'(sel))))));
`ifdef CRAM_DIAG_PARITY_EN
        if ((^rdata) == 1'b0) m_err = 1'b1;
`endif
        cram_rdata = rand80();
        tick();
        chk("rd_valid_once", 80'(rd_valid), 80'(1'b0));
        chk("rd_done_ready", 80'(ready), 80'(1'b1));
        chk("rd_err", 80'(err), 80'(m_err));
    endtask

    function automatic logic [79:0] mem_or_rand(input logic [10:0] a);
        if (mem.exists(a)) return mem[a];
        return rand80();
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] adr_c;
        logic [79:0] w_c;
        logic [35:0] abcde;
        int          r;

        RESET = 1'b1; func_valid = 1'b0; func_code = '0; ebus_data = '0;
        rd_req = 1'b0; rd_slice = '0; cram_rdata = '0;
        model_reset();
        tick();
        tick();
        chk_reset_outputs("reset");
        RESET = 1'b0;

        // Address 11'o1234 and four identical slices, then commit.
        adr_c = 11'o1234;
        abcde = 36'(20'hABCDE) << 16;
        do_func(3'd1, 36'(adr_c[5:0]) << 30);
        do_func(3'd2, 36'(adr_c[10:6]) << 30);
        for (int c = 4; c < 8; c++) do_func(3'(c), abcde);
        w_c = 80'hABCDE_ABCDE_ABCDE_ABCDE;
`ifdef CRAM_DIAG_PARITY_EN
        w_c[0] = ~^w_c[79:1];
`endif
        func_valid = 1'b1; func_code = 3'd3;
        tick();
        func_valid = 1'b0;
        $display("commit adr=%o", cram_adr);
        chk("dir_we", 80'(cram_we), 80'(1'b1));
        chk("dir_adr", 80'(cram_adr), 80'(adr_c));
        chk("dir_wdata", cram_wdata, w_c);
        mem[m_adr] = exp_wdata();
        m_mask = '0;
        tick();
        chk("dir_we_once", 80'(cram_we), 80'(1'b0));
        do_read(2'd1, mem[m_adr]);

        // Partial mask commit sets err; clear drops err and the mask.
        do_func(3'd0, '0);
        for (int c = 5; c < 8; c++) do_func(3'(c), 36'($urandom));
        do_func(3'd3, '0);
        chk("partial_err", 80'(err), 80'(1'b1));
        do_func(3'd0, '0);
        chk("clear_err", 80'(err), 80'(1'b0));
        do_func(3'd4, 36'($urandom));
        do_func(3'd3, '0);
        chk("mask_cleared", 80'(err), 80'(1'b1));
        do_func(3'd0, '0);

        // Read-back slice 40_59.
        do_read(2'd2, 80'h1_2345_6789_ABCD_EF01);
        chk("dir_rd_slice", 80'(cram_adr), 80'(m_adr));

        // Function strobe during WRITE is ignored.
        do_func(3'd0, '0);
        for (int c = 4; c < 8; c++) do_func(3'(c), 36'({$urandom, $urandom}));
        func_valid = 1'b1; func_code = 3'd3;
        tick();
        func_code = 3'd1; ebus_data = '1;
        $display("func during write");
        chk("wr_ready_low", 80'(ready), 80'(1'b0));
        chk("wr_we", 80'(cram_we), 80'(1'b1));
        mem[m_adr] = exp_wdata();
        m_mask = '0;
        tick();
        func_valid = 1'b0;
        chk("wr_func_ignored", 80'(cram_adr), 80'(m_adr));
        chk("wr_busy_done", 80'(busy), 80'(1'b0));

        // Simultaneous func and rd_req: func wins.
        func_valid = 1'b1; func_code = 3'd7; ebus_data = 36'({$urandom, $urandom});
        rd_req = 1'b1; rd_slice = 2'd1;
        tick();
        func_valid = 1'b0; rd_req = 1'b0;
        $display("func and read together");
        m_slice[0] = 20'(ebus_data >> 16);
        m_mask[0] = 1'b1;
        chk("both_no_re", 80'(cram_re), 80'(1'b0));
        chk("both_not_busy", 80'(busy), 80'(1'b0));
        tick();
        chk("both_no_valid", 80'(rd_valid), 80'(1'b0));

        // RESET in the cycle after commit aborts the write.
        for (int c = 4; c < 8; c++) do_func(3'(c), 36'({$urandom, $urandom}));
        func_valid = 1'b1; func_code = 3'd3;
        tick();
        func_valid = 1'b0;
        RESET = 1'b1;
        #1;
        $display("reset during write");
        chk("rst_wr_no_we", 80'(cram_we), 80'(1'b0));
        tick();
        chk_reset_outputs("rst_wr");
        RESET = 1'b0;
        model_reset();
        tick();
        chk("rst_wr_still_no_we", 80'(cram_we), 80'(1'b0));

        // RESET during READ.
        rd_req = 1'b1; rd_slice = 2'd0;
        tick();
        rd_req = 1'b0;
        RESET = 1'b1;
        #1;
        $display("reset during read");
        chk("rst_rd_no_re", 80'(cram_re), 80'(1'b0));
        tick();
        RESET = 1'b0;
        tick();
        chk("rst_rd_no_valid", 80'(rd_valid), 80'(1'b0));
        chk("rst_rd_ready", 80'(ready), 80'(1'b1));

        // Even-parity read data: err only when the parity check is built in.
        do_func(3'd0, '0);
        do_read(2'd3, 80'h3);
`ifdef CRAM_DIAG_PARITY_EN
        chk("par_even_err", 80'(err), 80'(1'b1));
`else
        chk("par_even_err", 80'(err), 80'(1'b0));
`endif
        do_func(3'd0, '0);
        do_read(2'd3, 80'h1);
        chk("par_odd_ok", 80'(err), 80'(1'b0));

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 9) begin
                do_func(3'($urandom_range(4, 7)), 36'({$urandom, $urandom}));
            end else if (r < 12) begin
                do_func(3'($urandom_range(1, 2)), 36'({$urandom, $urandom}));
            end else if (r < 15) begin
                do_func(3'd3, 36'($urandom));
            end else if (r < 19) begin
                do_read(2'($urandom), mem_or_rand(m_adr));
            end else begin
                do_func(3'd0, '0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
